// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: geometry defaults,
// FSM state encoding and address field width helpers.
package icache_pkg;

    localparam int IC_LINES = 16;
    localparam int IC_WORDS = 4;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;

    typedef enum logic [1:0] {
        IC_IDLE   = 2'd0,
        IC_REFILL = 2'd1,
        IC_RESP   = 2'd2
    } ic_state_t;

    // Word-offset field width.
    function automatic int off_w(input int words);
        return $clog2(words);
    endfunction

    // Line-index field width.
    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    // Tag width: everything above index, offset and the byte bits.
    function automatic int tag_w(input int lines, input int words);
        return ADDR_W - $clog2(words) - $clog2(lines) - 2;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Combinational read port; a single write port used by the refill path.
// Only the valid bits are reset; tags and data are plain storage.
module icache_array
    import icache_pkg::*;
#(
    parameter int LINES = IC_LINES,
    parameter int WORDS = IC_WORDS,
    localparam int OFF_W = off_w(WORDS),
    localparam int IDX_W = idx_w(LINES),
    localparam int TAG_W = tag_w(LINES, WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [OFF_W-1:0] rd_off,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_word,
    input  logic             wr_word_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [OFF_W-1:0] wr_off,
    input  logic [31:0]      wr_word,
    input  logic             wr_tag_en,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             set_valid,
    input  logic             flush_all
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES][WORDS];

    // Valid bits: flush wins over a same-cycle set so a flushed refill stays invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (flush_all) begin
            valid_q <= '0;
        end else if (set_valid) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag storage, written once per completed refill.
    always_ff @(posedge clk) begin
        if (wr_tag_en) begin
            tag_q[wr_idx] <= wr_tag;
        end
    end

    // Data storage, one word per refill beat.
    always_ff @(posedge clk) begin
        if (wr_word_en) begin
            data_q[wr_idx][wr_off] <= wr_word;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_word  = data_q[rd_idx][rd_off];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache. Hits answer combinationally;
// misses refill the whole line as an in-order burst and then return the
// requested word with a one-cycle valid pulse.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IC_IDLE   | serving hits; a miss latches the address and starts refill
//   IC_REFILL | mem_req held, beats written into the miss line in order
//   IC_RESP   | one-cycle return of the requested word from the new line
module icache
    import icache_pkg::*;
#(
    parameter int LINES = IC_LINES,
    parameter int WORDS = IC_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        icache_req,
    input  logic [31:0] icache_addr,
    output logic [31:0] icache_data,
    output logic        icache_valid,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid
);

    localparam int OFF_W = off_w(WORDS);
    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(LINES, WORDS);
    localparam int LSB   = OFF_W + 2;

    ic_state_t        state_q;
    logic [OFF_W-1:0] cnt_q;
    logic [31:2]      miss_addr_q;
    logic             flush_pend_q;
    logic             mem_req_q;
    logic [31:0]      mem_addr_q;

    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [OFF_W-1:0] miss_off;
    logic [IDX_W-1:0] miss_idx;
    logic [TAG_W-1:0] miss_tag;

    logic [IDX_W-1:0] rd_idx;
    logic [OFF_W-1:0] rd_off;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_word;

    logic             hit;
    logic             beat;
    logic             last_beat;
    logic [1:0]       unused_byte_bits;

    assign req_off  = icache_addr[LSB-1:2];
    assign req_idx  = icache_addr[LSB+IDX_W-1:LSB];
    assign req_tag  = icache_addr[31:LSB+IDX_W];
    assign miss_off = miss_addr_q[LSB-1:2];
    assign miss_idx = miss_addr_q[LSB+IDX_W-1:LSB];
    assign miss_tag = miss_addr_q[31:LSB+IDX_W];

    assign unused_byte_bits = icache_addr[1:0];

    // Outside IDLE the read port follows the latched miss so RESP sees the refilled line.
    assign rd_idx = (state_q == IC_IDLE) ? req_idx : miss_idx;
    assign rd_off = (state_q == IC_IDLE) ? req_off : miss_off;

    assign hit       = (state_q == IC_IDLE) && icache_req && rd_valid && (rd_tag == req_tag);
    assign beat      = (state_q == IC_REFILL) && mem_rvalid;
    assign last_beat = beat && (cnt_q == OFF_W'(WORDS - 1));

    icache_array #(
        .LINES (LINES),
        .WORDS (WORDS)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx     (rd_idx),
        .rd_off     (rd_off),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_word    (rd_word),
        .wr_word_en (beat),
        .wr_idx     (miss_idx),
        .wr_off     (cnt_q),
        .wr_word    (mem_rdata),
        .wr_tag_en  (last_beat),
        .wr_tag     (miss_tag),
        .set_valid  (last_beat && !flush_pend_q),
        .flush_all  (flush)
    );

    // Miss handling FSM with beat counter, miss latch and memory request outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IC_IDLE;
            cnt_q        <= '0;
            miss_addr_q  <= '0;
            flush_pend_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            case (state_q)
                IC_IDLE: begin
                    if (icache_req && !hit) begin
                        miss_addr_q <= icache_addr[31:2];
                        cnt_q       <= '0;
                        mem_req_q   <= 1'b1;
                        mem_addr_q  <= {icache_addr[31:LSB], {LSB{1'b0}}};
                        state_q     <= IC_REFILL;
                    end
                end
                IC_REFILL: begin
                    if (flush) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        cnt_q <= cnt_q + OFF_W'(1);
                        if (last_beat) begin
                            mem_req_q  <= 1'b0;
                            mem_addr_q <= '0;
                            state_q    <= IC_RESP;
                        end
                    end
                end
                IC_RESP: begin
                    flush_pend_q <= 1'b0;
                    state_q      <= IC_IDLE;
                end
                default: begin
                    state_q <= IC_IDLE;
                end
            endcase
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign icache_valid = hit || (state_q == IC_RESP);
    assign icache_data  = icache_valid ? rd_word : 32'h0;

endmodule
